// File: rtl/multicycle_control.sv
// Multicycle main control FSM for the RV64I core: sequences the shared ALU, PC, IR and memory port.
// Optional MULTICYCLE_PERF_EN adds cycle_cnt/instret_cnt performance counters.
module multicycle_control #(
    parameter int unsigned MEM_WAIT_MAX = 0
`ifdef MULTICYCLE_PERF_EN
    , parameter int unsigned CNT_W = 64
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       inst_opcode,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_src,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_addr_sel,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             illegal_inst,
    output logic             mem_fault,
    output logic [2:0]       state
`ifdef MULTICYCLE_PERF_EN
    , output logic [CNT_W-1:0] cycle_cnt
    , output logic [CNT_W-1:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_BRCMP = 2'b11;
    localparam logic [1:0] A_PC      = 2'b00;
    localparam logic [1:0] A_OLD_PC  = 2'b01;
    localparam logic [1:0] A_RS1     = 2'b10;
    localparam logic [1:0] A_ZERO    = 2'b11;
    localparam logic [1:0] B_RS2     = 2'b00;
    localparam logic [1:0] B_IMM     = 2'b01;
    localparam logic [1:0] B_CONST4  = 2'b10;
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam int unsigned WCNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    state_t              state_q, state_d;
    logic                illegal_q, illegal_d;
    logic                fault_q, fault_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WCNT_W-1:0]   wait_inc;
    logic                mem_pending;
    logic                opcode_legal;

    assign wait_inc = wait_cnt_q + WCNT_W'(1);

    always_comb begin
        opcode_legal = 1'b0;
        case (inst_opcode)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32, OPC_STORE,
            OPC_OP, OPC_LUI, OPC_OP_32, OPC_BRANCH, OPC_JALR, OPC_JAL: opcode_legal = 1'b1;
            default: opcode_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        fault_d      = fault_q;
        wait_cnt_d   = '0;
        alu_op       = ALU_ADD;
        alu_src_a    = A_PC;
        alu_src_b    = B_RS2;
        pc_src       = 1'b0;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALUOUT;
        mem_pending  = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = B_CONST4;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            // Branch/jump target is precomputed into ALUOUT while the opcode is decoded.
            DECODE: begin
                alu_src_a = A_OLD_PC;
                alu_src_b = B_IMM;
                if (opcode_legal) begin
                    state_d = EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            EXECUTE: begin
                case (inst_opcode)
                    OPC_OP, OPC_OP_32: begin
                        alu_op    = ALU_FUNCT;
                        alu_src_a = A_RS1;
                        alu_src_b = B_RS2;
                        state_d   = WRITEBACK;
                    end
                    OPC_OP_IMM, OPC_OP_IMM_32: begin
                        alu_op    = ALU_FUNCT;
                        alu_src_a = A_RS1;
                        alu_src_b = B_IMM;
                        state_d   = WRITEBACK;
                    end
                    OPC_LUI: begin
                        alu_src_a = A_ZERO;
                        alu_src_b = B_IMM;
                        state_d   = WRITEBACK;
                    end
                    OPC_AUIPC: begin
                        alu_src_a = A_OLD_PC;
                        alu_src_b = B_IMM;
                        state_d   = WRITEBACK;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_src_a = A_RS1;
                        alu_src_b = B_IMM;
                        state_d   = MEMORY;
                    end
                    OPC_BRANCH: begin
                        alu_op    = ALU_BRCMP;
                        alu_src_a = A_RS1;
                        alu_src_b = B_RS2;
                        pc_write  = branch_taken;
                        pc_src    = 1'b1;
                        state_d   = FETCH;
                    end
                    OPC_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                        state_d   = FETCH;
                    end
                    OPC_JALR: begin
                        alu_src_a = A_RS1;
                        alu_src_b = B_IMM;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                        state_d   = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEMORY: begin
                mem_addr_sel = 1'b1;
                if (inst_opcode == OPC_LOAD) begin
                    mem_read = 1'b1;
                    if (mem_ready) state_d = WRITEBACK;
                end else if (inst_opcode == OPC_STORE) begin
                    mem_write = 1'b1;
                    if (mem_ready) state_d = FETCH;
                end else begin
                    state_d = FETCH;
                end
            end
            WRITEBACK: begin
                reg_write = 1'b1;
                wb_sel    = (inst_opcode == OPC_LOAD) ? WB_MDR : WB_ALUOUT;
                state_d   = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = TRAP;
        endcase

        // A stalled access keeps the state unchanged, so the counter only survives while stalled.
        mem_pending = mem_read | mem_write;
        if (mem_pending && !mem_ready) begin
            if ((MEM_WAIT_MAX != 0) && (wait_inc == WCNT_W'(MEM_WAIT_MAX))) begin
                fault_d = 1'b1;
                state_d = TRAP;
            end else begin
                wait_cnt_d = wait_inc;
            end
        end

        if (!rst_n) begin
            alu_op       = 2'b00;
            alu_src_a    = 2'b00;
            alu_src_b    = 2'b00;
            pc_src       = 1'b0;
            pc_write     = 1'b0;
            ir_write     = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            mem_addr_sel = 1'b0;
            reg_write    = 1'b0;
            wb_sel       = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            illegal_q  <= 1'b0;
            fault_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            illegal_q  <= illegal_d;
            fault_q    <= fault_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign illegal_inst = illegal_q;
    assign mem_fault    = fault_q;
    assign state        = state_q;

`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    // An instruction retires whenever control returns to FETCH from elsewhere.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != TRAP) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (state_q != FETCH && state_d == FETCH) instret_cnt_d = instret_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule
